// File: rtl/ctrl_seq_if.sv
// Shared ALU opcode type and the sequencer's bus interface.
//
// global_pkg::alu_op : 6-bit ALU operation code; nop is the idle code.
//
// ctrl_seq_if groups the program-ROM and ALU connections of ctrl_seq:
//   ROM_Addr   sequencer -> ROM   program address (ADDR_W bits)
//   ROM_Data   ROM -> sequencer   program word, valid 1 cycle after ROM_Addr
//   ALU_op     sequencer -> ALU   operation, non-nop only in EXEC
//   ALU_InData sequencer -> ALU   data for load immediates
//   FlagZ      ALU -> sequencer   zero/compare flag
//   FlagE      ALU -> sequencer   error flag
// modport master is the sequencer side, modport slave the ROM/ALU side.

package global_pkg;

  typedef enum logic [5:0] {
    nop      = 6'd0,
    op_add   = 6'd1,
    op_sub   = 6'd2,
    op_and   = 6'd3,
    op_or    = 6'd4,
    op_xor   = 6'd5,
    op_not   = 6'd6,
    op_cmp   = 6'd7,
    op_lda   = 6'd8,
    op_ldb   = 6'd9,
    op_ldacc = 6'd10,
    op_ldid  = 6'd11,
    op_oeacc = 6'd12
  } alu_op;

  // Highest defined code; anything above decodes to nop.
  localparam logic [5:0] ALU_OP_LAST = 6'd12;

endpackage

interface ctrl_seq_if #(
  parameter int unsigned ADDR_W = 8
);

  logic [ADDR_W-1:0] ROM_Addr;
  logic [7:0]        ROM_Data;
  global_pkg::alu_op ALU_op;
  logic [7:0]        ALU_InData;
  logic              FlagZ;
  logic              FlagE;

  modport master (
    output ROM_Addr,
    output ALU_op,
    output ALU_InData,
    input  ROM_Data,
    input  FlagZ,
    input  FlagE
  );

  modport slave (
    input  ROM_Addr,
    input  ALU_op,
    input  ALU_InData,
    output ROM_Data,
    output FlagZ,
    output FlagE
  );

endinterface

// File: rtl/ctrl_seq.sv
// ctrl_seq: instruction sequencer for the microcontroller.
//
// Fetches 8-bit instructions from a synchronous program ROM (1-cycle read
// latency), decodes them and issues exactly one ALU operation per
// instruction. Two-word instructions carry an immediate operand used either
// as load data or as a jump target; jumps are resolved against the ALU flags.
//
// Ports:
//   Clk     in   clock, rising edge
//   Rst_n   in   asynchronous active-low reset
//   Start   in   1-cycle pulse, leaves IDLE (ignored elsewhere)
//   bus     if   ctrl_seq_if.master: ROM_Addr/ROM_Data, ALU_op/ALU_InData,
//                FlagZ/FlagE
//   Busy    out  1 while executing (FETCH/DECODE/OPERAND/EXEC)
//   Halted  out  1 once a HALT has been decoded
//
// Instruction word IR[7:6]:
//   00 ALU op IR[5:0] (undefined codes issue nop)
//   01 load immediate, IR[1:0]: lda / ldb / ldacc / ldid
//   10 jump to operand, IR[1:0]: always / Z / !Z / E
//   11 halt

module ctrl_seq #(
  parameter int unsigned       ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic           Clk,
  input  logic           Rst_n,
  input  logic           Start,
  ctrl_seq_if.master     bus,
  output logic           Busy,
  output logic           Halted
);

  import global_pkg::*;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_OPERAND,
    S_EXEC,
    S_HALTED
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] pc;
  logic [7:0]        ir;
  logic [7:0]        operand;
  logic              jump_taken;
  alu_op             op_c;
  logic [7:0]        data_c;

  // ROM address is the PC itself; the ROM word for the address presented in
  // FETCH arrives in DECODE, and the one presented in DECODE in OPERAND.
  assign bus.ROM_Addr   = pc;
  assign bus.ALU_op     = op_c;
  assign bus.ALU_InData = data_c;

  // Flags are those present during EXEC, i.e. left by the previous op.
  always_comb begin
    jump_taken = 1'b0;
    if (ir[7:6] == 2'b10) begin
      unique case (ir[1:0])
        2'b00: jump_taken = 1'b1;
        2'b01: jump_taken = bus.FlagZ;
        2'b10: jump_taken = ~bus.FlagZ;
        2'b11: jump_taken = bus.FlagE;
        default: jump_taken = 1'b0;
      endcase
    end
  end

  // State register
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:    if (Start) state_nxt = S_FETCH;
      S_FETCH:   state_nxt = S_DECODE;
      S_DECODE: begin
        unique case (bus.ROM_Data[7:6])
          2'b00:   state_nxt = S_EXEC;
          2'b11:   state_nxt = S_HALTED;
          default: state_nxt = S_OPERAND;
        endcase
      end
      S_OPERAND: state_nxt = S_EXEC;
      S_EXEC:    state_nxt = S_FETCH;
      S_HALTED:  state_nxt = S_HALTED;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Datapath registers: PC, instruction and operand
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      pc      <= RESET_PC;
      ir      <= '0;
      operand <= '0;
    end else begin
      unique case (state)
        S_FETCH: pc <= pc + ADDR_W'(1);
        S_DECODE: ir <= bus.ROM_Data;
        S_OPERAND: begin
          operand <= bus.ROM_Data;
          pc      <= pc + ADDR_W'(1);
        end
        S_EXEC: if (jump_taken) pc <= ADDR_W'(operand);
        default: ;
      endcase
    end
  end

  // Output logic: ALU signals are live only in EXEC
  always_comb begin
    op_c   = nop;
    data_c = '0;
    Busy   = 1'b0;
    Halted = 1'b0;
    unique case (state)
      S_FETCH, S_DECODE, S_OPERAND: Busy = 1'b1;
      S_EXEC: begin
        Busy = 1'b1;
        unique case (ir[7:6])
          2'b00: if (ir[5:0] <= ALU_OP_LAST) op_c = alu_op'(ir[5:0]);
          2'b01: begin
            data_c = operand;
            unique case (ir[1:0])
              2'b00:   op_c = op_lda;
              2'b01:   op_c = op_ldb;
              2'b10:   op_c = op_ldacc;
              2'b11:   op_c = op_ldid;
              default: op_c = nop;
            endcase
          end
          default: ;
        endcase
      end
      S_HALTED: Halted = 1'b1;
      default: ;
    endcase
  end

endmodule
